i2cmb_wb_sequencer: RTL and testbench
=====================================

I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max clk_i cycles to wait for irq_i per I2CMB command.
REQ-002 SHALL have parameter CSR_ENABLE_VAL, default 8'hC0, CSR value written on enable (E=1, IE=1).
REQ-003 SHALL have port clk_i, input, 1, single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid_i, input, 1, transaction request valid.
REQ-006 SHALL have port req_ready_o, output, 1, sequencer idle and able to accept a request.
REQ-007 SHALL have ports req_bus_i (input, 4, I2C bus id), req_addr_i (input, 7, slave address), req_rw_i (input, 1, 1=read), req_wdata_i (input, 8, write byte).
REQ-008 SHALL have ports rsp_valid_o (output, 1, one-cycle completion pulse), rsp_rdata_o (output, 8, read byte), rsp_status_o (output, 2, 00 OK, 01 NAK, 10 arbitration lost, 11 timeout/error).
REQ-009 SHALL have Wishbone master ports wb_cyc_o, wb_stb_o, wb_we_o (output, 1 each), wb_adr_o (output, 2), wb_dat_o (output, 8), wb_dat_i (input, 8), wb_ack_i (input, 1), plus irq_i (input, 1, I2CMB interrupt).

Function
REQ-010 SHALL use I2CMB register map CSR=0, DPR=1, CMDR=2 and commands SET_BUS=110, START=100, WRITE=001, READ_NAK=011, STOP=101.
REQ-011 SHALL accept a request on the cycle req_valid_i && req_ready_o, capture all req_* fields, and drive req_ready_o low until the cycle after rsp_valid_o.
REQ-012 SHALL perform each Wishbone access as one classic cycle: assert wb_cyc_o and wb_stb_o with adr/dat/we stable, hold until wb_ack_i, deassert both the cycle after ack, one access outstanding at a time.
REQ-013 SHALL, if an internal enabled flag is 0, first write CSR=CSR_ENABLE_VAL, then set the flag.
REQ-014 SHALL define a command step as: optional DPR write, CMDR write of the command, WAIT_IRQ until irq_i=1, then CMDR read to obtain status (DON=bit7, NAK=bit6, AL=bit5, ERR=bit4).
REQ-015 SHALL sequence steps: SET_BUS (DPR=bus), START, WRITE (DPR={addr,rw}), then WRITE (DPR=wdata) if rw=0 or READ_NAK followed by DPR read into rsp_rdata_o if rw=1, then STOP.
REQ-016 SHALL, on NAK status after any WRITE, skip remaining data steps, execute STOP, and respond 01.
REQ-017 SHALL, on AL status, skip STOP and respond 10 immediately; on ERR status, respond 11 without STOP.
REQ-018 SHALL count clk_i cycles in WAIT_IRQ; on reaching TIMEOUT_CYCLES, write CSR=8'h00, clear the enabled flag, and respond 11.
REQ-019 SHALL pulse rsp_valid_o for exactly one cycle with rsp_rdata_o/rsp_status_o valid that cycle, holding them until the next response; rsp_rdata_o SHALL be 8'h00 for writes.
REQ-020 SHALL ignore irq_i outside WAIT_IRQ and ignore wb_ack_i when wb_stb_o=0.
REQ-021 SHALL, if irq_i and timeout expiry coincide, treat it as irq (no timeout).

Reset
REQ-022 SHALL, while rst_i=1, drive all outputs to 0 including req_ready_o, clear enabled flag and timeout counter, and return to IDLE; reset mid-transaction SHALL abort with no response pulse.
REQ-023 SHALL assert req_ready_o=1 on the first clk_i edge after rst_i deasserts.

Verification
REQ-024 Write: bus=2, addr=0x22, rw=0, wdata=0xA5, slave ACKs -> WB writes CSR=C0, DPR=02, CMDR=06, CMDR=04, DPR=44, CMDR=01, DPR=A5, CMDR=01, CMDR=05 with CMDR reads between; rsp status 00.
REQ-025 Read: bus=0, addr=0x10, rw=1, slave returns 0x3C -> DPR=21, CMDR=03, DPR read, rsp_rdata_o=0x3C, status 00; CSR not rewritten on second request.
REQ-026 Address NAK: CMDR read returns 0x40 after address write -> no data step, STOP issued, status 01.
REQ-027 Timeout: irq_i held low, TIMEOUT_CYCLES=16 -> CSR=00 written after 16 wait cycles, status 11; next request rewrites CSR=C0.
REQ-028 Arbitration lost: CMDR read returns 0x20 after START -> no STOP, status 10; rst_i asserted mid-WAIT_IRQ -> all outputs 0, no rsp_valid_o.

Source files
------------

// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that drives an I2CMB core through one complete I2C byte transaction
// (bus select, start, address, one data byte, stop) and reports a single response.
module i2cmb_wb_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  CSR_ENABLE_VAL = 8'hC0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_bus_i,
    input  logic [6:0] req_addr_i,
    input  logic       req_rw_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_status_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [1:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    input  logic       irq_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;

    localparam logic [2:0] CMD_SET_BUS  = 3'b110;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_STOP     = 3'b101;

    localparam logic [1:0] RSP_OK  = 2'b00;
    localparam logic [1:0] RSP_NAK = 2'b01;
    localparam logic [1:0] RSP_AL  = 2'b10;
    localparam logic [1:0] RSP_ERR = 2'b11;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CSR_EN  = 4'd1;
    localparam logic [3:0] ST_DPR_WR  = 4'd2;
    localparam logic [3:0] ST_CMD_WR  = 4'd3;
    localparam logic [3:0] ST_WAIT    = 4'd4;
    localparam logic [3:0] ST_STAT    = 4'd5;
    localparam logic [3:0] ST_DPR_RD  = 4'd6;
    localparam logic [3:0] ST_CSR_DIS = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // Command steps run in this numeric order; advancing is step + 1.
    localparam logic [2:0] STEP_BUS   = 3'd0;
    localparam logic [2:0] STEP_START = 3'd1;
    localparam logic [2:0] STEP_ADDR  = 3'd2;
    localparam logic [2:0] STEP_DATA  = 3'd3;
    localparam logic [2:0] STEP_STOP  = 3'd4;

    logic [3:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic             enabled_q, enabled_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [7:0]       rdata_q, rdata_d;

    logic [3:0] bus_q;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;

    logic       ready_d, rsp_valid_d;
    logic [7:0] rsp_rdata_d;
    logic [1:0] rsp_status_d;
    logic       cyc_d, stb_d, we_d;
    logic [1:0] adr_d;
    logic [7:0] dat_d;

    logic       accept_c;
    logic       done_c;
    logic       fin_c;
    logic [1:0] fin_status_c;
    logic       acc_c;
    logic       acc_we_c;
    logic [1:0] acc_adr_c;
    logic [7:0] acc_dat_c;
    logic [2:0] step_cmd_c;
    logic [7:0] step_dpr_c;
    logic       step_is_write_c;

    function automatic logic step_has_dpr(input logic [2:0] s, input logic rw);
        return (s == STEP_BUS) || (s == STEP_ADDR) || ((s == STEP_DATA) && !rw);
    endfunction

    // Command code and DPR payload of the current step
    always_comb begin
        step_cmd_c = CMD_STOP;
        step_dpr_c = wdata_q;
        case (step_q)
            STEP_BUS:   begin step_cmd_c = CMD_SET_BUS; step_dpr_c = {4'd0, bus_q}; end
            STEP_START: step_cmd_c = CMD_START;
            STEP_ADDR:  begin step_cmd_c = CMD_WRITE; step_dpr_c = {addr_q, rw_q}; end
            STEP_DATA:  step_cmd_c = rw_q ? CMD_READ_NAK : CMD_WRITE;
            default:    step_cmd_c = CMD_STOP;
        endcase
        step_is_write_c = (step_q == STEP_ADDR) || ((step_q == STEP_DATA) && !rw_q);
    end

    // Wishbone access owned by each bus state
    always_comb begin
        acc_c     = 1'b0;
        acc_we_c  = 1'b0;
        acc_adr_c = ADR_CSR;
        acc_dat_c = 8'h00;
        case (state_q)
            ST_CSR_EN:  begin acc_c = 1'b1; acc_we_c = 1'b1; acc_dat_c = CSR_ENABLE_VAL; end
            ST_DPR_WR:  begin acc_c = 1'b1; acc_we_c = 1'b1; acc_adr_c = ADR_DPR; acc_dat_c = step_dpr_c; end
            ST_CMD_WR:  begin acc_c = 1'b1; acc_we_c = 1'b1; acc_adr_c = ADR_CMDR; acc_dat_c = {5'd0, step_cmd_c}; end
            ST_STAT:    begin acc_c = 1'b1; acc_adr_c = ADR_CMDR; end
            ST_DPR_RD:  begin acc_c = 1'b1; acc_adr_c = ADR_DPR; end
            ST_CSR_DIS: begin acc_c = 1'b1; acc_we_c = 1'b1; end
            default:    acc_c = 1'b0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        enabled_d    = enabled_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_o;
        rsp_status_d = rsp_status_o;
        cyc_d        = wb_cyc_o;
        stb_d        = wb_stb_o;
        we_d         = wb_we_o;
        adr_d        = wb_adr_o;
        dat_d        = wb_dat_o;
        accept_c     = 1'b0;
        done_c       = 1'b0;
        fin_c        = 1'b0;
        fin_status_c = RSP_OK;

        // A bus state launches its access after one idle cycle, so the strobe
        // always drops for at least a cycle between back-to-back accesses.
        if (acc_c) begin
            if (!wb_cyc_o) begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                we_d  = acc_we_c;
                adr_d = acc_adr_c;
                dat_d = acc_dat_c;
            end else if (wb_ack_i) begin
                cyc_d  = 1'b0;
                stb_d  = 1'b0;
                we_d   = 1'b0;
                adr_d  = 2'd0;
                dat_d  = 8'h00;
                done_c = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid_i && req_ready_o) begin
                    accept_c = 1'b1;
                    ready_d  = 1'b0;
                    pend_d   = RSP_OK;
                    rdata_d  = 8'h00;
                    step_d   = STEP_BUS;
                    state_d  = enabled_q ? ST_DPR_WR : ST_CSR_EN;
                end
            end
            ST_CSR_EN: begin
                if (done_c) begin
                    enabled_d = 1'b1;
                    state_d   = ST_DPR_WR;
                end
            end
            ST_DPR_WR: begin
                if (done_c) state_d = ST_CMD_WR;
            end
            ST_CMD_WR: begin
                if (done_c) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (irq_i) begin
                    state_d = ST_STAT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_CSR_DIS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAT: begin
                if (done_c) begin
                    if (wb_dat_i[5]) begin
                        fin_c        = 1'b1;
                        fin_status_c = RSP_AL;
                    end else if (wb_dat_i[4]) begin
                        fin_c        = 1'b1;
                        fin_status_c = RSP_ERR;
                    end else if (step_q == STEP_STOP) begin
                        fin_c        = 1'b1;
                        fin_status_c = pend_q;
                    end else if (wb_dat_i[6] && step_is_write_c) begin
                        pend_d  = RSP_NAK;
                        step_d  = STEP_STOP;
                        state_d = ST_CMD_WR;
                    end else if ((step_q == STEP_DATA) && rw_q) begin
                        state_d = ST_DPR_RD;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = step_has_dpr(step_q + 3'd1, rw_q) ? ST_DPR_WR : ST_CMD_WR;
                    end
                end
            end
            ST_DPR_RD: begin
                if (done_c) begin
                    rdata_d = wb_dat_i;
                    step_d  = STEP_STOP;
                    state_d = ST_CMD_WR;
                end
            end
            ST_CSR_DIS: begin
                if (done_c) begin
                    enabled_d    = 1'b0;
                    fin_c        = 1'b1;
                    fin_status_c = RSP_ERR;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin_c) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = fin_status_c;
            rsp_rdata_d  = rw_q ? rdata_q : 8'h00;
            state_d      = ST_DONE;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            step_q       <= STEP_BUS;
            enabled_q    <= 1'b0;
            cnt_q        <= '0;
            pend_q       <= RSP_OK;
            rdata_q      <= 8'h00;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= 8'h00;
            rsp_status_o <= 2'b00;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= 2'd0;
            wb_dat_o     <= 8'h00;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            enabled_q    <= enabled_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            rdata_q      <= rdata_d;
            req_ready_o  <= ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_rdata_o  <= rsp_rdata_d;
            rsp_status_o <= rsp_status_d;
            wb_cyc_o     <= cyc_d;
            wb_stb_o     <= stb_d;
            wb_we_o      <= we_d;
            wb_adr_o     <= adr_d;
            wb_dat_o     <= dat_d;
        end
    end

    // Request capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_q   <= 4'd0;
            addr_q  <= 7'd0;
            rw_q    <= 1'b0;
            wdata_q <= 8'h00;
        end else if (accept_c) begin
            bus_q   <= req_bus_i;
            addr_q  <= req_addr_i;
            rw_q    <= req_rw_i;
            wdata_q <= req_wdata_i;
        end
    end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: an I2CMB stand-in answers the Wishbone bus while a
// transaction-level model predicts every access and every response.
module tb_i2cmb_wb_sequencer;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_bus = 4'd0;
    logic [6:0] req_addr = 7'd0;
    logic       req_rw = 1'b0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_status;
    logic       wb_cyc, wb_stb, wb_we;
    logic [1:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_ack = 1'b0;
    logic       irq = 1'b0;

    i2cmb_wb_sequencer #(.TIMEOUT_CYCLES(TO), .CSR_ENABLE_VAL(8'hC0)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_rw_i(req_rw), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .irq_i(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scenario knobs shared by the I2CMB stand-in and the model
    logic [2:0] st_cmd = 3'd0;
    int         st_nth = 0;
    logic [7:0] st_val = 8'h80;
    int         to_cmd = -1;
    int         irq_lat = 3;
    logic [7:0] read_byte = 8'h00;

    // I2CMB stand-in
    int         s_cnt[8];
    logic [2:0] last_cmd = 3'd0;
    int         irq_cnt = -1;
    logic [9:0] wlog[$];

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                wb_ack = 1'b0; wb_dat_i = 8'h00; irq = 1'b0; irq_cnt = -1;
            end else begin
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) irq = 1'b1;
                end
                if (wb_ack) begin
                    wb_ack = 1'b0; wb_dat_i = 8'h00;
                end else if (wb_stb) begin
                    wb_ack = 1'b1;
                    if (wb_we) begin
                        wlog.push_back({wb_adr, wb_dat_o});
                        if (wb_adr == 2'd2) begin
                            last_cmd = wb_dat_o[2:0];
                            s_cnt[last_cmd]++;
                            if (int'(last_cmd) != to_cmd) irq_cnt = irq_lat;
                        end
                    end else if (wb_adr == 2'd2) begin
                        irq = 1'b0;
                        wb_dat_i = (last_cmd == st_cmd && s_cnt[last_cmd] == st_nth) ? st_val : 8'h80;
                    end else if (wb_adr == 2'd1) begin
                        wb_dat_i = read_byte;
                    end
                end
            end
        end
    end

    // Transaction-level model: {we, adr, dat} per expected access
    logic [10:0] exp_q[$];
    bit          m_en = 1'b0;
    int          m_cnt[8];
    logic [1:0]  exp_status = 2'b00;
    logic [7:0]  exp_rdata = 8'h00;

    // outcome: 0 ok, 1 NAK on a write, 2 arbitration lost, 3 error, 4 timeout
    task automatic m_step(input bit has_dpr, input logic [7:0] dpr, input logic [2:0] cmd, output int o);
        logic [7:0] sts;
        if (has_dpr) exp_q.push_back({1'b1, 2'd1, dpr});
        exp_q.push_back({1'b1, 2'd2, {5'd0, cmd}});
        m_cnt[cmd]++;
        if (int'(cmd) == to_cmd) begin
            exp_q.push_back({1'b1, 2'd0, 8'h00});
            m_en = 1'b0;
            o = 4;
        end else begin
            exp_q.push_back({1'b0, 2'd2, 8'h00});
            sts = (cmd == st_cmd && m_cnt[cmd] == st_nth) ? st_val : 8'h80;
            if (sts[5]) o = 2;
            else if (sts[4]) o = 3;
            else if (sts[6] && cmd == 3'b001) o = 1;
            else o = 0;
        end
    endtask

    task automatic build(input logic [3:0] bus, input logic [6:0] addr, input logic rw, input logic [7:0] wd);
        int  o;
        bit  fin;
        logic [1:0] pend;
        exp_q.delete();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        exp_rdata = 8'h00;
        fin = 0; pend = 2'b00; exp_status = 2'b00;
        if (!m_en) begin
            exp_q.push_back({1'b1, 2'd0, 8'hC0});
            m_en = 1'b1;
        end
        m_step(1'b1, {4'd0, bus}, 3'b110, o);
        if (o >= 2) begin fin = 1; exp_status = (o == 2) ? 2'b10 : 2'b11; end
        if (!fin) begin
            m_step(1'b0, 8'h00, 3'b100, o);
            if (o >= 2) begin fin = 1; exp_status = (o == 2) ? 2'b10 : 2'b11; end
        end
        if (!fin) begin
            m_step(1'b1, {addr, rw}, 3'b001, o);
            if (o == 1) pend = 2'b01;
            else if (o >= 2) begin fin = 1; exp_status = (o == 2) ? 2'b10 : 2'b11; end
        end
        if (!fin && pend == 2'b00) begin
            if (!rw) begin
                m_step(1'b1, wd, 3'b001, o);
                if (o == 1) pend = 2'b01;
                else if (o >= 2) begin fin = 1; exp_status = (o == 2) ? 2'b10 : 2'b11; end
            end else begin
                m_step(1'b0, 8'h00, 3'b011, o);
                if (o >= 2) begin fin = 1; exp_status = (o == 2) ? 2'b10 : 2'b11; end
                else begin
                    exp_q.push_back({1'b0, 2'd1, 8'h00});
                    exp_rdata = read_byte;
                end
            end
        end
        if (!fin) begin
            m_step(1'b0, 8'h00, 3'b101, o);
            if (o >= 2) exp_status = (o == 2) ? 2'b10 : 2'b11;
            else exp_status = pend;
        end
    endtask

    // Compare process
    logic        prev_stb = 1'b0;
    logic        prev_rsp = 1'b0;
    logic [10:0] prev_bus = '0;
    int          idle_cnt = 0;
    bit          m_busy = 1'b0;
    logic [1:0]  hold_status = 2'b00;
    logic [7:0]  hold_rdata = 8'h00;

    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            check("reset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_status, wb_cyc, wb_stb,
                                        wb_we, wb_adr, wb_dat_o}), 32'd0);
            prev_stb = 1'b0; prev_rsp = 1'b0; idle_cnt = 0; m_busy = 1'b0;
            hold_status = 2'b00; hold_rdata = 8'h00;
        end else begin
            check("cyc_eq_stb", 32'(wb_cyc), 32'(wb_stb));
            if (wb_stb && !prev_stb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("access_we_adr", 32'({wb_we, wb_adr}), 32'(e[10:8]));
                    if (e[10]) check("access_wdata", 32'(wb_dat_o), 32'(e[7:0]));
                    if (e == 11'h400)
                        check("timeout_gap", 32'(idle_cnt >= int'(TO) && idle_cnt <= int'(TO) + 2), 32'd1);
                end
            end
            if (wb_stb && prev_stb) check("access_stable", 32'({wb_we, wb_adr, wb_dat_o}), 32'(prev_bus));
            idle_cnt = wb_stb ? 0 : idle_cnt + 1;
            if (prev_rsp) check("ready_after_rsp", 32'(req_ready), 32'd1);
            if (m_busy) check("ready_low_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                check("rsp_expected", 32'(m_busy), 32'd1);
                check("rsp_one_cycle", 32'(prev_rsp), 32'd0);
                check("rsp_status", 32'(rsp_status), 32'(exp_status));
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                check("rsp_accesses_done", 32'(exp_q.size()), 32'd0);
                hold_status = exp_status; hold_rdata = exp_rdata;
                m_busy = 1'b0;
            end else begin
                check("rsp_hold", 32'({rsp_status, rsp_rdata}), 32'({hold_status, hold_rdata}));
            end
            if (req_valid && req_ready) m_busy = 1'b1;
            prev_stb = wb_stb;
            prev_rsp = rsp_valid;
            prev_bus = {wb_we, wb_adr, wb_dat_o};
        end
    end

    task automatic start_txn(input logic [3:0] bus, input logic [6:0] addr, input logic rw, input logic [7:0] wd);
        bit got = 0;
        build(bus, addr, rw, wd);
        foreach (s_cnt[i]) s_cnt[i] = 0;
        wlog.delete();
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin got = 1; break; end
            @(posedge clk); #1;
        end
        check("ready_before_req", 32'(got), 32'd1);
        req_bus = bus; req_addr = addr; req_rw = rw; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin got = 1; break; end
        end
        check("rsp_arrived", 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [9:0] exp_w[9] = '{10'h0C0, 10'h102, 10'h206, 10'h204, 10'h144,
                             10'h201, 10'h1A5, 10'h201, 10'h205};

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("ready_first_edge", 32'(req_ready), 32'd1);

        // Write with slave ACK, first request enables the core
        start_txn(4'd2, 7'h22, 1'b0, 8'hA5);
        wait_rsp();
        check("model_status_w", 32'(exp_status), 32'd0);
        check("w_log_size", 32'(wlog.size()), 32'd9);
        for (int i = 0; i < 9 && i < wlog.size(); i++) check("w_log_entry", 32'(wlog[i]), 32'(exp_w[i]));
        check("w_status", 32'(rsp_status), 32'd0);
        check("w_rdata", 32'(rsp_rdata), 32'd0);

        // Read, CSR not rewritten
        read_byte = 8'h3C;
        start_txn(4'd0, 7'h10, 1'b1, 8'h00);
        wait_rsp();
        check("r_rdata", 32'(rsp_rdata), 32'h3C);
        check("r_status", 32'(rsp_status), 32'd0);
        check("r_first_write", 32'(wlog.size() > 0 ? wlog[0] : 10'h3FF), 32'h100);
        check("r_addr_byte", 32'(wlog.size() > 3 ? wlog[3] : 10'h3FF), 32'h121);

        // Address NAK
        st_cmd = 3'b001; st_nth = 1; st_val = 8'h40;
        start_txn(4'd1, 7'h50, 1'b0, 8'h11);
        wait_rsp();
        check("anak_status", 32'(rsp_status), 32'd1);
        check("anak_log_size", 32'(wlog.size()), 32'd6);
        check("anak_stop", 32'(wlog.size() > 0 ? wlog[wlog.size() - 1] : 10'h3FF), 32'h205);

        // Data NAK
        st_nth = 2;
        start_txn(4'd3, 7'h05, 1'b0, 8'h5A);
        wait_rsp();
        check("dnak_status", 32'(rsp_status), 32'd1);

        // Arbitration lost on START
        st_cmd = 3'b100; st_nth = 1; st_val = 8'h20;
        start_txn(4'd1, 7'h33, 1'b1, 8'h00);
        wait_rsp();
        check("al_status", 32'(rsp_status), 32'd2);
        check("al_log_size", 32'(wlog.size()), 32'd3);
        check("al_rdata", 32'(rsp_rdata), 32'd0);

        // Error on SET_BUS
        st_cmd = 3'b110; st_nth = 1; st_val = 8'h10;
        start_txn(4'd7, 7'h01, 1'b0, 8'h00);
        wait_rsp();
        check("err_status", 32'(rsp_status), 32'd3);

        // Timeout on SET_BUS
        st_nth = 0; to_cmd = 6;
        start_txn(4'd4, 7'h44, 1'b0, 8'h99);
        wait_rsp();
        check("to_status", 32'(rsp_status), 32'd3);
        check("to_csr_off", 32'(wlog.size() > 0 ? wlog[wlog.size() - 1] : 10'h3FF), 32'h000);

        // Re-enable after timeout, slow irq still inside the window
        to_cmd = -1; irq_lat = 14;
        start_txn(4'd2, 7'h22, 1'b0, 8'h3C);
        wait_rsp();
        check("reen_status", 32'(rsp_status), 32'd0);
        check("reen_csr", 32'(wlog.size() > 0 ? wlog[0] : 10'h3FF), 32'h0C0);

        // Reset while waiting for START's irq
        irq_lat = 3; to_cmd = 4;
        start_txn(4'd1, 7'h11, 1'b1, 8'h00);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            foreach (wlog[j]) if (wlog[j] == 10'h204) seen = 1;
            if (seen) break;
        end
        check("rst_start_issued", 32'(seen), 32'd1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete(); m_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_outputs", 32'({req_ready, rsp_valid, wb_cyc, wb_stb}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);

        to_cmd = -1; read_byte = 8'hE7;
        start_txn(4'd5, 7'h7F, 1'b1, 8'h00);
        wait_rsp();
        check("post_rst_rdata", 32'(rsp_rdata), 32'hE7);
        check("post_rst_csr", 32'(wlog.size() > 0 ? wlog[0] : 10'h3FF), 32'h0C0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
